// File: rtl/sram_sp_param.sv
// Parametrised single-port synchronous SRAM with byte enables, 1/2-cycle
// registered read latency, out-of-range error pulse and optional post-reset
// zero-fill sequencer that holds off requests until the array is cleared.
module sram_sp_param #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  w_r,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  ready,
    output logic                  err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t ST_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     cnt_d;
    logic                 ready_d;
    logic                 clr_we_c;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 acc_c;
    logic                 in_range_c;
    logic                 wr_c;
    logic                 rd_c;
    logic [IDX_W-1:0]     idx_c;
    logic [DATA_W-1:0]    rd_word_c;

    // Request decode: accept only while ready; out-of-range reads yield zero
    always_comb begin
        acc_c      = en && ready;
        in_range_c = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
        wr_c       = acc_c && w_r && in_range_c;
        rd_c       = acc_c && !w_r;
        idx_c      = IDX_W'(addr);
        rd_word_c  = '0;
        if (in_range_c) begin
            rd_word_c = mem[idx_c];
        end
    end

    // Next-state logic for the clear sweep and the ready flag
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready;
        clr_we_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, sweep counter and ready registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready   <= ready_d;
        end
    end

    // Storage array: clear sweep or byte-masked write (no reset on the array)
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[cnt_q] <= '0;
        end else if (wr_c) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Error pulse one cycle after an accepted out-of-range request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= acc_c && !in_range_c;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;

            // Two-stage read pipeline; rdata holds between reads
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    rvalid   <= 1'b0;
                    rdata    <= '0;
                end else begin
                    s1_valid <= rd_c;
                    if (rd_c) begin
                        s1_data <= rd_word_c;
                    end
                    rvalid <= s1_valid;
                    if (s1_valid) begin
                        rdata <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read; rdata holds between reads
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid <= 1'b0;
                    rdata  <= '0;
                end else begin
                    rvalid <= rd_c;
                    if (rd_c) begin
                        rdata <= rd_word_c;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_sp_param.sv
// Directed bench: instance A (16-bit, depth 16, 2-cycle read, clear on reset)
// and instance B (8-bit, depth 12, 1-cycle read, no clear).
module tb_sram_sp_param;

    logic        clk;
    int          n_checks;
    int          n_fail;

    logic        rst_a_n, en_a, w_r_a;
    logic [3:0]  addr_a;
    logic [1:0]  be_a;
    logic [15:0] wdata_a, rdata_a;
    logic        rvalid_a, ready_a, err_a;

    logic        rst_b_n, en_b, w_r_b;
    logic [3:0]  addr_b;
    logic [0:0]  be_b;
    logic [7:0]  wdata_b, rdata_b;
    logic        rvalid_b, ready_b, err_b;

    sram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_dut_a (
        .clk(clk), .rst_n(rst_a_n), .en(en_a), .w_r(w_r_a), .addr(addr_a), .be(be_a),
        .wdata(wdata_a), .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a), .err(err_a)
    );

    sram_sp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_LAT(1), .CLEAR_ON_RESET(0)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .en(en_b), .w_r(w_r_b), .addr(addr_b), .be(be_b),
        .wdata(wdata_b), .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        en_a = 1'b1; w_r_a = 1'b1; addr_a = a; wdata_a = d; be_a = b;
        tick();
        en_a = 1'b0; w_r_a = 1'b0;
    endtask

    task automatic write_b(input logic [3:0] a, input logic [7:0] d, input logic [0:0] b);
        en_b = 1'b1; w_r_b = 1'b1; addr_b = a; wdata_b = d; be_b = b;
        tick();
        en_b = 1'b0; w_r_b = 1'b0;
    endtask

    // Counts edges until ready_a rises, also counting stray rvalid pulses
    task automatic wait_ready_a(output int edges, output int rv_seen);
        edges = 0;
        rv_seen = 0;
        while (!ready_a && edges < 40) begin
            tick();
            edges++;
            if (rvalid_a) rv_seen++;
        end
    endtask

    task automatic test_reset();
        int edges, rv_seen;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        en_a = 1'b0; w_r_a = 1'b0; addr_a = '0; be_a = '0; wdata_a = '0;
        en_b = 1'b0; w_r_b = 1'b0; addr_b = '0; be_b = '0; wdata_b = '0;
        #12;
        n_checks++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata_a: got %h want 0000", rdata_a); end
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_a: got %b want 0", rvalid_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a: got %b want 0", ready_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b want 0", err_a); end
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b: got %b want 0", ready_b); end
        n_checks++; if (rdata_b !== 8'h00) begin n_fail++; $display("FAIL reset_rdata_b: got %h want 00", rdata_b); end
        // Hold read requests through the clear sweep
        en_a = 1'b1; w_r_a = 1'b0; addr_a = 4'd0;
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        wait_ready_a(edges, rv_seen);
        n_checks++; if (edges !== 16) begin n_fail++; $display("FAIL clear_ready_edges: got %0d want 16", edges); end
        n_checks++; if (rv_seen !== 0) begin n_fail++; $display("FAIL clear_no_rvalid: got %0d want 0", rv_seen); end
        // Back-to-back reads of every address must see zero
        for (int j = 0; j <= 16; j++) begin
            en_a = (j < 16);
            addr_a = 4'(j);
            tick();
            if (j >= 1) begin
                n_checks++; if (rvalid_a !== 1'b1) begin n_fail++; $display("FAIL clear_read_rvalid[%0d]: got %b want 1", j-1, rvalid_a); end
                n_checks++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL clear_read_data[%0d]: got %h want 0000", j-1, rdata_a); end
            end
        end
        en_a = 1'b0;
        tick();
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL clear_read_tail: got %b want 0", rvalid_a); end
    endtask

    task automatic test_byte_enable();
        write_a(4'd3, 16'hABCD, 2'b11);
        write_a(4'd3, 16'h1234, 2'b01);
        n_checks++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL be_write_keeps_rdata: got %h want 0000", rdata_a); end
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL be_write_no_rvalid: got %b want 0", rvalid_a); end
        en_a = 1'b1; w_r_a = 1'b0; addr_a = 4'd3;
        tick();
        en_a = 1'b0;
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL be_lat2_early: got %b want 0", rvalid_a); end
        tick();
        n_checks++; if (rvalid_a !== 1'b1) begin n_fail++; $display("FAIL be_rvalid: got %b want 1", rvalid_a); end
        n_checks++; if (rdata_a !== 16'hAB34) begin n_fail++; $display("FAIL be_rdata: got %h want ab34", rdata_a); end
        tick();
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL be_rvalid_pulse: got %b want 0", rvalid_a); end
        n_checks++; if (rdata_a !== 16'hAB34) begin n_fail++; $display("FAIL be_rdata_hold: got %h want ab34", rdata_a); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        for (int k = 0; k < 4; k++) write_a(4'(k), 16'(10 + k), 2'b11);
        for (int j = 0; j <= 5; j++) begin
            en_a = (j < 4); w_r_a = 1'b0;
            addr_a = 4'(j);
            tick();
            if (j >= 1 && j <= 4) begin
                exp = 16'(10 + j - 1);
                n_checks++; if (rvalid_a !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", j, rvalid_a); end
                n_checks++; if (rdata_a !== exp) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %0d want %0d", j, rdata_a, exp); end
            end else begin
                n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_edge[%0d]: got %b want 0", j, rvalid_a); end
            end
            n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL b2b_err[%0d]: got %b want 0", j, err_a); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int edges, rv_seen;
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL midclear_ready_cnt5: got %b want 0", ready_a); end
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        wait_ready_a(edges, rv_seen);
        n_checks++; if (edges !== 16) begin n_fail++; $display("FAIL midclear_restart_edges: got %0d want 16", edges); end
    endtask

    task automatic test_reset_inflight();
        int edges, rv_seen;
        write_a(4'd5, 16'hBEEF, 2'b11);
        en_a = 1'b1; w_r_a = 1'b0; addr_a = 4'd5;
        tick();
        en_a = 1'b0;
        tick();
        n_checks++; if (rdata_a !== 16'hBEEF) begin n_fail++; $display("FAIL inflight_pre_read: got %h want beef", rdata_a); end
        en_a = 1'b1; addr_a = 4'd5;
        tick();
        en_a = 1'b0;
        #2;
        rst_a_n = 1'b0;
        #1;
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL inflight_rvalid_async: got %b want 0", rvalid_a); end
        n_checks++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL inflight_rdata_async: got %h want 0000", rdata_a); end
        tick();
        n_checks++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL inflight_rvalid_held: got %b want 0", rvalid_a); end
        rst_a_n = 1'b1;
        wait_ready_a(edges, rv_seen);
        n_checks++; if (rv_seen !== 0) begin n_fail++; $display("FAIL inflight_no_rvalid: got %0d want 0", rv_seen); end
        n_checks++; if (edges !== 16) begin n_fail++; $display("FAIL inflight_ready_edges: got %0d want 16", edges); end
        n_checks++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL inflight_rdata_after: got %h want 0000", rdata_a); end
    endtask

    task automatic test_no_clear();
        @(posedge clk); #1;
        rst_b_n = 1'b1;
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL noclear_ready_pre: got %b want 0", ready_b); end
        tick();
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL noclear_ready_1edge: got %b want 1", ready_b); end
        write_b(4'd0, 8'h5A, 1'b1);
        en_b = 1'b1; w_r_b = 1'b0; addr_b = 4'd0;
        tick();
        en_b = 1'b0;
        n_checks++; if (rvalid_b !== 1'b1) begin n_fail++; $display("FAIL noclear_rvalid: got %b want 1", rvalid_b); end
        n_checks++; if (rdata_b !== 8'h5A) begin n_fail++; $display("FAIL noclear_rdata: got %h want 5a", rdata_b); end
        tick();
        n_checks++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL noclear_rvalid_pulse: got %b want 0", rvalid_b); end
        n_checks++; if (rdata_b !== 8'h5A) begin n_fail++; $display("FAIL noclear_rdata_hold: got %h want 5a", rdata_b); end
        // be=0 write must leave the word untouched
        write_b(4'd0, 8'h00, 1'b0);
        en_b = 1'b1; w_r_b = 1'b0; addr_b = 4'd0;
        tick();
        en_b = 1'b0;
        n_checks++; if (rdata_b !== 8'h5A) begin n_fail++; $display("FAIL noclear_be0_noop: got %h want 5a", rdata_b); end
    endtask

    task automatic test_out_of_range();
        write_b(4'd11, 8'h77, 1'b1);
        n_checks++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL oor_err_in_range_wr: got %b want 0", err_b); end
        en_b = 1'b1; w_r_b = 1'b1; addr_b = 4'd13; wdata_b = 8'hFF; be_b = 1'b1;
        tick();
        en_b = 1'b0; w_r_b = 1'b0;
        n_checks++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL oor_err_wr13: got %b want 1", err_b); end
        n_checks++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL oor_wr_no_rvalid: got %b want 0", rvalid_b); end
        tick();
        n_checks++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b want 0", err_b); end
        en_b = 1'b1; addr_b = 4'd13;
        tick();
        n_checks++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL oor_err_rd13: got %b want 1", err_b); end
        n_checks++; if (rvalid_b !== 1'b1) begin n_fail++; $display("FAIL oor_rvalid_rd13: got %b want 1", rvalid_b); end
        n_checks++; if (rdata_b !== 8'h00) begin n_fail++; $display("FAIL oor_rdata_rd13: got %h want 00", rdata_b); end
        addr_b = 4'd11;
        tick();
        n_checks++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL oor_err_rd11: got %b want 0", err_b); end
        n_checks++; if (rdata_b !== 8'h77) begin n_fail++; $display("FAIL oor_rdata_rd11: got %h want 77", rdata_b); end
        addr_b = 4'd12;
        tick();
        en_b = 1'b0;
        n_checks++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL oor_err_rd12: got %b want 1", err_b); end
        n_checks++; if (rdata_b !== 8'h00) begin n_fail++; $display("FAIL oor_rdata_rd12: got %h want 00", rdata_b); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_reset_mid_clear();
        test_reset_inflight();
        test_no_clear();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_sp_param.md
# sram_sp_param

Parametrised single-port synchronous SRAM, the successor to the team's fixed 8-bit × 16 single-port memory. It adds configurable width and depth, per-byte write enables, and separate write and read data buses instead of a tristate bus. It also adds a selectable 1- or 2-cycle registered read latency with a valid strobe, and an optional post-reset zero-fill sequencer that gates access until the array is cleared. It sits as a local scratch/buffer memory behind a simple request/strobe master.

## Interface
Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8
- ADDR_W, 4, address width
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- CLEAR_ON_RESET, 1, if 1, zero-fill the array after reset before accepting requests

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- rst_n  input  1  reset, asynchronous and active-low
- en  input  1  request strobe; one request per cycle
- w_r  input  1  1 = write, 0 = read; sampled with en
- addr  input  ADDR_W  word address
- be  input  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i]; ignored on reads
- wdata  input  DATA_W  write data
- rdata  output  DATA_W  registered read data
- rvalid  output  1  one-cycle pulse, rdata valid
- ready  output  1  high when requests are accepted
- err  output  1  one-cycle pulse, accepted request addressed ≥ DEPTH

## Operation
- Accepted request = en && ready at a posedge. Requests while ready=0 are dropped with no side effects.
- FSM states:
  - CLEAR: 0→DEPTH-1 counter, writes all-zero words.
  - RUN: normal access.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR: each posedge writes mem[cnt]=0 and increments cnt. The edge writing DEPTH-1 moves to RUN and sets ready=1.
- CLEAR_ON_RESET=0: ready rises on the first posedge after rst_n deasserts. Array contents are undefined until written.
- Write (w_r=1): for each i with be[i]=1, mem[addr] byte i ← wdata byte i. Other bytes are unchanged. be=0 is a legal no-op write. No rvalid is produced.
- Read (w_r=0): issues a read of mem[addr] and produces exactly one rvalid pulse.
- Out-of-range address (addr ≥ DEPTH):
  - write: dropped, memory unchanged.
  - read: returns all-zero data with normal rvalid timing.
  - err pulses on the cycle after acceptance.
- rdata holds its last read value between reads. Writes never alter rdata.
- Back-to-back reads every cycle are supported at full throughput for both RD_LAT values. Read order is preserved.
- Asynchronous reset, including mid-CLEAR or with reads in flight:
  - clears pending read pipeline stages; no rvalid is emitted for reads in flight.
  - rdata=0, rvalid=0, err=0, ready=0.
  - FSM returns to its reset state with cnt=0.
  - The array itself has no reset; only the CLEAR sweep zeros it.

## Timing
- Reset values: rdata=0, rvalid=0, ready=0, err=0, cnt=0.
- Read accepted at edge N:
  - RD_LAT=1: rdata/rvalid valid after edge N, i.e. during cycle N+1.
  - RD_LAT=2: valid after edge N+1; rvalid aligned with rdata.
- Write accepted at edge N: a read of the same address accepted at edge N+1 returns the new data.
- CLEAR_ON_RESET=1: ready rises after exactly DEPTH posedges following rst_n deassertion. The first accepted request is possible on edge DEPTH+1.
- err is asserted in the same cycle as the request's effect (the cycle after edge N), independent of RD_LAT.

## Test plan
- Reset clear: DATA_W=16, DEPTH=16, CLEAR=1.
  - Stimulus: after rst_n release, hold en=1 reads; count edges.
  - Required: ready=1 after 16 edges, no rvalid before that, and reads of all 16 addresses return 16'h0000.
- Byte enables: write addr 3 wdata=16'hABCD be=2'b11, then wdata=16'h1234 be=2'b01, then read addr 3.
  - Required: rdata=16'hAB34 with rvalid.
- Latency and throughput: RD_LAT=2.
  - Stimulus: write addrs 0..3 with values 10..13, then issue reads 0,1,2,3 on consecutive edges.
  - Required: rvalid high on 4 consecutive cycles starting 2 cycles after the first read, with data 10,11,12,13.
- Out-of-range: DEPTH=12, ADDR_W=4.
  - Stimulus: write addr 13 value 8'hFF, then read addr 13, then read addr 11.
  - Required: err pulses on both addr-13 requests, the addr-13 read returns 0, and addr 11 is unchanged.
- Reset mid-operation:
  - Assert rst_n=0 during CLEAR at cnt=5 → CLEAR restarts from 0 and ready rises DEPTH edges after release.
  - Assert rst_n=0 with a RD_LAT=2 read in flight → no rvalid is emitted and rdata=0.
- No-clear mode: CLEAR_ON_RESET=0.
  - Required: ready=1 one edge after reset release, and a write then read of addr 0 with 8'h5A returns 8'h5A.
